seq_recursive_mul8: RTL and testbench

SEQ_RECURSIVE_MUL8 -- requirements
Module: seq_recursive_mul8

---
 rtl/seq_recursive_mul8.sv | 102 ++++++++++
 tb/tb_seq_recursive_mul8.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seq_recursive_mul8.sv
// Sequential 8x8 unsigned multiplier built from one shared 2x2 digit core.
// Sixteen digit products are accumulated one per cycle; APPROX selects the digit rule.
module seq_recursive_mul8 #(
  parameter int unsigned APPROX = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  step_q, step_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] acc_q, acc_d;

  logic [1:0]  dig_a, dig_b;
  logic [3:0]  pp;
  logic [2:0]  weight;
  logic [15:0] pp_shifted;

  // Step k pairs a-digit k[1:0] with b-digit k[3:2].
  always_comb begin
    dig_a      = a_q[{step_q[1:0], 1'b0} +: 2];
    dig_b      = b_q[{step_q[3:2], 1'b0} +: 2];
    weight     = {1'b0, step_q[1:0]} + {1'b0, step_q[3:2]};
    pp_shifted = {12'd0, pp} << {weight, 1'b0};
  end

  generate
    if (APPROX != 0) begin : g_approx
      // Drops the carry out of the middle column, so 3x3 gives 7.
      assign pp = {1'b0,
                   dig_a[1] & dig_b[1],
                   (dig_a[0] & dig_b[1]) | (dig_a[1] & dig_b[0]),
                   dig_a[0] & dig_b[0]};
    end else begin : g_exact
      assign pp = {2'b00, dig_a} * {2'b00, dig_b};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = 16'd0;
          step_d  = 4'd0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        acc_d  = acc_q + pp_shifted;
        step_d = step_q + 4'd1;
        if (step_q == 4'd15) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      step_q  <= 4'd0;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      acc_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign product   = acc_q;

endmodule

// File: tb/tb_seq_recursive_mul8.sv
// Bench for seq_recursive_mul8: both digit rules run side by side on shared stimulus,
// checked per cycle against an arithmetic model plus hand-computed literal results.
module tb_seq_recursive_mul8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [7:0]  a_in = 8'd0;
  logic [7:0]  b_in = 8'd0;
  logic        in_ready_apx, in_ready_ext;
  logic        ov_apx, ov_ext;
  logic [15:0] prod_apx, prod_ext;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_recursive_mul8 #(.APPROX(1)) u_dut_apx (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_apx),
    .a(a_in), .b(b_in), .out_valid(ov_apx), .out_ready(out_ready), .product(prod_apx)
  );

  seq_recursive_mul8 #(.APPROX(0)) u_dut_ext (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_ext),
    .a(a_in), .b(b_in), .out_valid(ov_ext), .out_ready(out_ready), .product(prod_ext)
  );

  // Approximate product: exact a*b minus 2 units of weight for every 3x3 digit pair.
  function automatic int approx_mul(input logic [7:0] x, input logic [7:0] y);
    int p;
    p = int'(x) * int'(y);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (((x >> (2 * i)) & 8'd3) == 8'd3 && ((y >> (2 * j)) & 8'd3) == 8'd3) begin
          p = p - (2 << (2 * (i + j)));
        end
      end
    end
    return p;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Protocol model: 0 idle, 1 computing (16 edges), 2 result held.
  int m_st = 0;
  int m_cnt = 0;
  int m_exp_a = 0;
  int m_exp_e = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st  <= 0;
      m_cnt <= 0;
    end else begin
      case (m_st)
        0: if (in_valid) begin
          m_st    <= 1;
          m_cnt   <= 0;
          m_exp_e <= int'(a_in) * int'(b_in);
          m_exp_a <= approx_mul(a_in, b_in);
        end
        1: begin
          m_cnt <= m_cnt + 1;
          if (m_cnt == 15) m_st <= 2;
        end
        default: if (out_ready) m_st <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("cyc_in_ready_apx", int'(in_ready_apx), int'(m_st == 0));
    chk("cyc_in_ready_ext", int'(in_ready_ext), int'(m_st == 0));
    chk("cyc_out_valid_apx", int'(ov_apx), int'(m_st == 2));
    chk("cyc_out_valid_ext", int'(ov_ext), int'(m_st == 2));
    if (m_st == 2) begin
      chk("cyc_product_apx", int'(prod_apx), m_exp_a);
      chk("cyc_product_ext", int'(prod_ext), m_exp_e);
    end
  end

  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input int ea, input int ee,
                        input int stall, input bit noise);
    int n;
    int lat;
    n = 0;
    while (!in_ready_apx && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_in_ready", int'(in_ready_apx), 1);
    a_in      = av;
    b_in      = bv;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_in     = 8'($urandom);
    b_in     = 8'($urandom);
    lat = 0;
    while (!ov_apx && lat < 40) begin
      if (noise) begin
        in_valid = 1'($urandom);
        a_in     = 8'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", lat, 16);
    chk("lit_product_apx", int'(prod_apx), ea);
    chk("lit_product_ext", int'(prod_ext), ee);
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      b_in     = 8'($urandom);
      @(posedge clk); #1;
      chk("stall_out_valid", int'(ov_apx), 1);
      chk("stall_in_ready", int'(in_ready_ext), 0);
      chk("stall_product_apx", int'(prod_apx), ea);
      chk("stall_product_ext", int'(prod_ext), ee);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", int'(in_ready_apx), 1);
    chk("release_out_valid", int'(ov_ext), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ra, rb;
    #1;
    chk("reset_in_ready", int'(in_ready_apx), 1);
    chk("reset_out_valid", int'(ov_apx), 0);
    chk("reset_product", int'(prod_ext), 0);
    #11 rst_n = 1'b1;

    // Pin the model against hand-computed values.
    chk("model_ff_apx", approx_mul(8'hFF, 8'hFF), 50575);
    chk("model_0f_apx", approx_mul(8'h0F, 8'h0F), 175);
    chk("model_03_apx", approx_mul(8'h03, 8'h03), 7);

    run_op(8'h03, 8'h03, 7, 9, 0, 1'b0);
    run_op(8'hFF, 8'hFF, 50575, 65025, 0, 1'b0);
    run_op(8'h0F, 8'h0F, 175, 225, 0, 1'b0);
    run_op(8'h00, 8'hA5, 0, 0, 0, 1'b0);
    run_op(8'h12, 8'h34, 16'h03A8, 16'h03A8, 5, 1'b1);

    // Abort mid-computation: reset lands around step 7.
    @(posedge clk); #1;
    a_in = 8'hFF; b_in = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", int'(in_ready_apx), 1);
    chk("abort_out_valid", int'(ov_ext), 0);
    chk("abort_product_apx", int'(prod_apx), 0);
    chk("abort_product_ext", int'(prod_ext), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (30) begin
      @(posedge clk); #1;
      chk("abort_no_valid", int'(ov_apx | ov_ext), 0);
    end
    run_op(8'hFF, 8'hFF, 50575, 65025, 0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      ra = int'($urandom_range(255, 0));
      rb = int'($urandom_range(255, 0));
      run_op(8'(ra), 8'(rb), approx_mul(8'(ra), 8'(rb)), ra * rb, k % 3, k[0]);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
